// File: rtl/apb_master.sv
// Requester-side APB bridge: turns single valid/ready commands into APB SETUP/ACCESS transfers.
// Optional ACCESS timeout is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  input  logic [7:0] cmd_waits,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_error,
  output logic       sel,
  output logic       enable,
  output logic       write,
  output logic [7:0] addr,
  output logic [7:0] wdata,
  output logic [7:0] waits,
  input  logic       ready,
  input  logic [7:0] rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t state_r;
  state_t state_nx;
  logic   accept_s;
  logic   done_s;
  logic   tmo_s;
  logic   timeout_hit_s;

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be in 1..255");
  end

  assign accept_s = cmd_valid & cmd_ready;

  // Next-state decode; ready outside ACCESS is deliberately ignored.
  always_comb begin
    state_nx = state_r;
    done_s   = 1'b0;
    tmo_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nx = ST_SETUP;
        else          state_nx = ST_IDLE;
      end
      ST_SETUP: begin
        state_nx = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (ready) begin
          done_s   = 1'b1;
          state_nx = ST_IDLE;
        end else if (timeout_hit_s) begin
          tmo_s    = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_ACCESS;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State register with APB handshake outputs registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cmd_ready <= 1'b1;
      sel       <= 1'b0;
      enable    <= 1'b0;
    end else begin
      state_r   <= state_nx;
      cmd_ready <= (state_nx == ST_IDLE);
      sel       <= (state_nx != ST_IDLE);
      enable    <= (state_nx == ST_ACCESS);
    end
  end

  // Command fields are captured only on acceptance, so they hold through the transfer and in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write <= 1'b0;
      addr  <= 8'h00;
      wdata <= 8'h00;
      waits <= 8'h00;
    end else if (accept_s) begin
      write <= cmd_write;
      addr  <= cmd_addr;
      wdata <= cmd_wdata;
      waits <= cmd_waits;
    end
  end

  // Response strobe; data holds until the next completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      rsp_valid <= done_s | tmo_s;
      if (done_s) begin
        rsp_rdata <= write ? 8'h00 : rdata;
      end else if (tmo_s) begin
        rsp_rdata <= 8'h00;
      end
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tmo_cnt_r;

  assign timeout_hit_s = (tmo_cnt_r == TMO_LAST);

  // Counts ACCESS cycles without ready; held at zero outside ACCESS so it is clear on entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_r <= 8'h00;
    end else if (state_r != ST_ACCESS) begin
      tmo_cnt_r <= 8'h00;
    end else if (!ready) begin
      tmo_cnt_r <= tmo_cnt_r + 8'h01;
    end
  end

  // Error flag follows the same hold-until-next-response rule as the read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_error <= 1'b0;
    end else if (done_s) begin
      rsp_error <= 1'b0;
    end else if (tmo_s) begin
      rsp_error <= 1'b1;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
  assign rsp_error     = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// Directed self-checking bench for apb_master; inputs change and outputs are sampled on negedge.
module tb_apb_master;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic [7:0] cmd_waits;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_error;
  logic       sel;
  logic       enable;
  logic       write;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] waits;
  logic       ready;
  logic [7:0] rdata;

  int passed = 0;
  int total  = 0;

  apb_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_waits(cmd_waits),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .sel(sel), .enable(enable), .write(write), .addr(addr), .wdata(wdata), .waits(waits),
    .ready(ready), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_cmd(input logic w, input logic [7:0] a, input logic [7:0] d, input logic [7:0] ws);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_waits = ws;
  endtask

  task automatic test_reset();
    tick();
    total++; if (sel !== 1'b0) $display("FAIL rst_sel got %b exp 0", sel); else passed++;
    total++; if (enable !== 1'b0) $display("FAIL rst_enable got %b exp 0", enable); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); else passed++;
    total++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); else passed++;
    total++; if (addr !== 8'h00) $display("FAIL rst_addr got %h exp 00", addr); else passed++;
    reset = 1'b0;
    tick();
    drive_cmd(1'b0, 8'h66, 8'h00, 8'd5);
    tick();
    cmd_valid = 1'b0;
    tick();
    total++; if (enable !== 1'b1) $display("FAIL rst_pre_access got %b exp 1", enable); else passed++;
    ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    total++; if (sel !== 1'b0) $display("FAIL rst_async_sel got %b exp 0", sel); else passed++;
    total++; if (enable !== 1'b0) $display("FAIL rst_async_enable got %b exp 0", enable); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL rst_async_rsp_valid got %b exp 0", rsp_valid); else passed++;
    tick();
    reset = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (rsp_valid !== 1'b0) $display("FAIL rst_no_rsp[%0d] got %b exp 0", i, rsp_valid); else passed++;
      total++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready_after[%0d] got %b exp 1", i, cmd_ready); else passed++;
      total++; if (sel !== 1'b0) $display("FAIL rst_sel_after[%0d] got %b exp 0", i, sel); else passed++;
    end
  endtask

  task automatic test_zero_wait_write();
    drive_cmd(1'b1, 8'h12, 8'hA5, 8'd0);
    tick();
    cmd_valid = 1'b0;
    total++; if ({sel, enable, cmd_ready} !== 3'b100) $display("FAIL wr_setup sel/en/rdy got %b exp 100", {sel, enable, cmd_ready}); else passed++;
    total++; if ({write, addr, wdata, waits} !== {1'b1, 8'h12, 8'hA5, 8'h00}) $display("FAIL wr_fields got %h exp %h", {write, addr, wdata, waits}, {1'b1, 8'h12, 8'hA5, 8'h00}); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL wr_setup_rsp got %b exp 0", rsp_valid); else passed++;
    tick();
    total++; if ({sel, enable, cmd_ready} !== 3'b110) $display("FAIL wr_access sel/en/rdy got %b exp 110", {sel, enable, cmd_ready}); else passed++;
    ready = 1'b1;
    rdata = 8'hFF;
    tick();
    ready = 1'b0;
    total++; if (rsp_valid !== 1'b1) $display("FAIL wr_rsp_valid got %b exp 1", rsp_valid); else passed++;
    total++; if (rsp_error !== 1'b0) $display("FAIL wr_rsp_error got %b exp 0", rsp_error); else passed++;
    total++; if (rsp_rdata !== 8'h00) $display("FAIL wr_rsp_rdata got %h exp 00", rsp_rdata); else passed++;
    total++; if ({sel, enable, cmd_ready} !== 3'b001) $display("FAIL wr_done sel/en/rdy got %b exp 001", {sel, enable, cmd_ready}); else passed++;
    tick();
    total++; if (rsp_valid !== 1'b0) $display("FAIL wr_rsp_pulse got %b exp 0", rsp_valid); else passed++;
  endtask

  task automatic test_wait_read();
    drive_cmd(1'b0, 8'h40, 8'h00, 8'd3);
    rdata = 8'hEE;
    tick();
    cmd_valid = 1'b0;
    total++; if ({sel, enable} !== 2'b10) $display("FAIL rd_setup sel/en got %b exp 10", {sel, enable}); else passed++;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (enable !== 1'b1) $display("FAIL rd_enable[%0d] got %b exp 1", i, enable); else passed++;
      total++; if (addr !== 8'h40) $display("FAIL rd_addr[%0d] got %h exp 40", i, addr); else passed++;
      total++; if (rsp_valid !== 1'b0) $display("FAIL rd_early_rsp[%0d] got %b exp 0", i, rsp_valid); else passed++;
      if (i == 3) begin
        ready = 1'b1;
        rdata = 8'h5C;
      end
    end
    tick();
    ready = 1'b0;
    rdata = 8'h00;
    total++; if (rsp_valid !== 1'b1) $display("FAIL rd_rsp_valid got %b exp 1", rsp_valid); else passed++;
    total++; if (rsp_rdata !== 8'h5C) $display("FAIL rd_rsp_rdata got %h exp 5c", rsp_rdata); else passed++;
    total++; if (enable !== 1'b0) $display("FAIL rd_enable_done got %b exp 0", enable); else passed++;
    tick();
    total++; if (rsp_valid !== 1'b0) $display("FAIL rd_rsp_pulse got %b exp 0", rsp_valid); else passed++;
    total++; if (rsp_rdata !== 8'h5C) $display("FAIL rd_rdata_hold got %h exp 5c", rsp_rdata); else passed++;
  endtask

  task automatic test_back_to_back();
    drive_cmd(1'b1, 8'h21, 8'h11, 8'd1);
    tick();
    total++; if ({sel, enable, addr} !== {2'b10, 8'h21}) $display("FAIL b2b_setup1 got %h exp %h", {sel, enable, addr}, {2'b10, 8'h21}); else passed++;
    drive_cmd(1'b0, 8'h33, 8'h22, 8'd2);
    tick();
    total++; if ({enable, write, addr, wdata, waits} !== {1'b1, 1'b1, 8'h21, 8'h11, 8'h01}) $display("FAIL b2b_access1 got %h exp %h", {enable, write, addr, wdata, waits}, {1'b1, 1'b1, 8'h21, 8'h11, 8'h01}); else passed++;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    total++; if ({rsp_valid, sel, cmd_ready} !== 3'b101) $display("FAIL b2b_gap got %b exp 101", {rsp_valid, sel, cmd_ready}); else passed++;
    total++; if (addr !== 8'h21) $display("FAIL b2b_gap_addr got %h exp 21", addr); else passed++;
    tick();
    cmd_valid = 1'b0;
    total++; if ({sel, enable, cmd_ready} !== 3'b100) $display("FAIL b2b_setup2 got %b exp 100", {sel, enable, cmd_ready}); else passed++;
    total++; if ({write, addr, wdata, waits} !== {1'b0, 8'h33, 8'h22, 8'h02}) $display("FAIL b2b_fields2 got %h exp %h", {write, addr, wdata, waits}, {1'b0, 8'h33, 8'h22, 8'h02}); else passed++;
    tick();
    ready = 1'b1;
    rdata = 8'h77;
    tick();
    ready = 1'b0;
    total++; if ({rsp_valid, rsp_rdata} !== {1'b1, 8'h77}) $display("FAIL b2b_rsp2 got %h exp %h", {rsp_valid, rsp_rdata}, {1'b1, 8'h77}); else passed++;
    tick();
  endtask

  task automatic test_ready_outside_access();
    ready = 1'b1;
    rdata = 8'h3C;
    tick();
    total++; if (rsp_valid !== 1'b0) $display("FAIL ext_idle_rsp got %b exp 0", rsp_valid); else passed++;
    drive_cmd(1'b0, 8'h0F, 8'h00, 8'd0);
    tick();
    cmd_valid = 1'b0;
    total++; if ({sel, enable, rsp_valid} !== 3'b100) $display("FAIL ext_setup got %b exp 100", {sel, enable, rsp_valid}); else passed++;
    tick();
    ready = 1'b0;
    total++; if ({sel, enable, rsp_valid} !== 3'b110) $display("FAIL ext_setup_ignored got %b exp 110", {sel, enable, rsp_valid}); else passed++;
    tick();
    total++; if ({enable, rsp_valid} !== 2'b10) $display("FAIL ext_access_wait got %b exp 10", {enable, rsp_valid}); else passed++;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    total++; if ({rsp_valid, rsp_rdata} !== {1'b1, 8'h3C}) $display("FAIL ext_rsp got %h exp %h", {rsp_valid, rsp_rdata}, {1'b1, 8'h3C}); else passed++;
    tick();
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    drive_cmd(1'b0, 8'h55, 8'h00, 8'd9);
    rdata = 8'hAA;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if ({enable, rsp_valid} !== 2'b10) $display("FAIL tmo_wait[%0d] got %b exp 10", i, {enable, rsp_valid}); else passed++;
    end
    tick();
    total++; if ({rsp_valid, rsp_error, rsp_rdata} !== {2'b11, 8'h00}) $display("FAIL tmo_rsp got %h exp %h", {rsp_valid, rsp_error, rsp_rdata}, {2'b11, 8'h00}); else passed++;
    total++; if ({sel, cmd_ready} !== 2'b01) $display("FAIL tmo_idle got %b exp 01", {sel, cmd_ready}); else passed++;
    tick();
    drive_cmd(1'b0, 8'h56, 8'h00, 8'd3);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin
        ready = 1'b1;
        rdata = 8'h99;
      end
    end
    tick();
    ready = 1'b0;
    total++; if ({rsp_valid, rsp_error, rsp_rdata} !== {2'b10, 8'h99}) $display("FAIL tmo_ready_wins got %h exp %h", {rsp_valid, rsp_error, rsp_rdata}, {2'b10, 8'h99}); else passed++;
    tick();
  endtask
`else
  task automatic test_no_timeout();
    drive_cmd(1'b0, 8'h55, 8'h00, 8'd12);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if ({enable, rsp_valid, rsp_error} !== 3'b100) $display("FAIL notmo_wait[%0d] got %b exp 100", i, {enable, rsp_valid, rsp_error}); else passed++;
    end
    ready = 1'b1;
    rdata = 8'h99;
    tick();
    ready = 1'b0;
    total++; if ({rsp_valid, rsp_error, rsp_rdata} !== {2'b10, 8'h99}) $display("FAIL notmo_rsp got %h exp %h", {rsp_valid, rsp_error, rsp_rdata}, {2'b10, 8'h99}); else passed++;
    tick();
  endtask
`endif

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 8'h00;
    cmd_wdata = 8'h00;
    cmd_waits = 8'h00;
    ready     = 1'b0;
    rdata     = 8'h00;
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_back_to_back();
    test_ready_outside_access();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

- Requester-side APB bridge (the counterpart of the APB slave).
- Accepts single 8-bit read/write commands on a valid/ready command port.
- Runs each command as one APB SETUP/ACCESS transfer, waiting on `ready` for as long as it takes.
- Returns read data (or a timeout error) on a one-cycle response strobe.
- Sits between the host logic or I2C controller and the APB master modport signals.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: ACCESS cycles allowed before abort. Range 1–255. Used only with `APB_MASTER_TIMEOUT_EN`.

Ports:
- `clk` input 1: single clock; all logic on posedge.
- `reset` input 1: asynchronous, active-high reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: command accepted on posedge when both are high.
- `cmd_write` input 1: 1 = write, 0 = read.
- `cmd_addr` input 8: target address.
- `cmd_wdata` input 8: write data; ignored for reads.
- `cmd_waits` input 8: wait-state count forwarded to the slave.
- `rsp_valid` output 1: one-cycle completion pulse.
- `rsp_rdata` output 8: captured `rdata`; 0 for writes and errors.
- `rsp_error` output 1: transfer aborted by timeout; qualified by `rsp_valid`.
- `sel` output 1: APB select.
- `enable` output 1: APB enable.
- `write` output 1: APB direction.
- `addr` output 8: APB address.
- `wdata` output 8: APB write data.
- `waits` output 8: APB wait-state request.
- `ready` input 1: APB slave ready.
- `rdata` input 8: APB slave read data.

## Operation
- States: IDLE, SETUP, ACCESS.
- **IDLE**
  - `cmd_ready`=1, `sel`=0, `enable`=0.
  - On accept, latch `cmd_write`/`cmd_addr`/`cmd_wdata`/`cmd_waits` into `write`/`addr`/`wdata`/`waits`, then go to SETUP.
- **SETUP**
  - Exactly one cycle: `sel`=1, `enable`=0, `cmd_ready`=0.
  - Then go to ACCESS.
- **ACCESS**
  - `sel`=1, `enable`=1, `cmd_ready`=0.
  - Each posedge samples `ready`.
  - `ready`=1: capture `rdata` into `rsp_rdata` for reads (0 for writes), pulse `rsp_valid`, go to IDLE.
- `addr`/`wdata`/`write`/`waits` stay stable from SETUP through the last ACCESS cycle. They hold their last value in IDLE.
- Every transfer is followed by at least one IDLE cycle with `sel`=0. This stops the slave from re-triggering on a stale select while it returns from its done state.
- `cmd_valid` held through IDLE is accepted on the first IDLE posedge. There is no internal queue; back-pressure is through `cmd_ready` only.
- `ready` seen high in IDLE or SETUP is ignored.
- Reset (asynchronous):
  - All outputs go to 0, except `cmd_ready`, which is 1 once in IDLE.
  - State goes to IDLE; timeout counter is cleared.
- Reset in SETUP or ACCESS drops the transfer with no `rsp_valid`.

## Timing
- Cycle numbering: command accepted at posedge T0.
  - T0→T1: `sel`=1 (SETUP).
  - T1→T2: `enable`=1 (ACCESS).
- Completion: if `ready` is first sampled high at posedge Tn (n≥2):
  - `rsp_valid`=1 during Tn→Tn+1.
  - `sel`=`enable`=0 from Tn.
  - `cmd_ready`=1 from Tn.
- Earliest next acceptance is posedge Tn+1. Next `sel` high is then Tn+1→Tn+2, so minimum back-to-back spacing is 1 idle cycle.
- With the slave's wait count W, total command-to-response latency is the slave's W+1 cycles of ACCESS plus one SETUP cycle.
- `rsp_rdata` and `rsp_error` hold until the next `rsp_valid`.

## Configuration
- **`APB_MASTER_TIMEOUT_EN` defined**
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle without `ready`.
  - When the count reaches `TIMEOUT_CYCLES` with `ready` still 0: `rsp_valid`=1, `rsp_error`=1, `rsp_rdata`=0, state → IDLE.
  - `ready` and timeout in the same cycle: `ready` wins, no error.
- **Not defined**
  - No counter; ACCESS waits indefinitely.
  - `rsp_error` is tied to 0.

## Test plan
- **Reset:** assert `reset` mid-ACCESS → `sel`/`enable`/`rsp_valid` are 0 immediately without a clock edge. After release: `cmd_ready`=1 and no response is issued.
- **Zero-wait write:** addr 0x12, wdata 0xA5, waits 0; slave raises `ready` on the first ACCESS edge → SETUP for 1 cycle, ACCESS for 1 cycle, `rsp_valid` pulse, `rsp_error`=0, `rsp_rdata`=0.
- **Wait-state read:** addr 0x40, waits 3; slave drives `rdata`=0x5C with `ready` after 3 waits → `enable` high for 4 cycles, `rsp_rdata`=0x5C, address stable throughout.
- **Back-to-back:** `cmd_valid` held for two commands → exactly one `sel`=0 cycle between transfers, and the second command's fields appear only in its own SETUP.
- **Timeout (macro on, `TIMEOUT_CYCLES`=4):** `ready` held 0 → after 4 ACCESS cycles `rsp_valid`=1, `rsp_error`=1, `rsp_rdata`=0. Repeat with `ready`=1 exactly on the 4th cycle → `rsp_error`=0.
- **Ready outside ACCESS:** slave pulses `ready` in IDLE and in SETUP → no `rsp_valid`, and the transfer still completes normally.
